song_sequencer: RTL and testbench

Top-level playback controller that sequences `song_reader`. It turns one-cycle button pulses into the reader's `play` level, `song` select and a restart pulse. It also reacts to `song_done` by advancing to the next song or rewinding the current one. It sits between the button one-pulse logic and `song_reader`. The top level ORs `reset_player` with the system reset to form the reader's `reset`.

---
 rtl/song_sequencer_pkg.sv | 19 +
 rtl/song_sequencer_hold_timer.sv | 42 ++++
 rtl/song_sequencer.sv | 127 ++++++++++++
 tb/tb_song_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/song_sequencer_pkg.sv
// song_sequencer_pkg
// Shared types and helpers for the song playback sequencer.
//   seqState_e : sequencer FSM states (pause / play / switch)
//   nextSong   : wrapping song index increment
package song_sequencer_pkg;

  // Encodings are fixed so the states line up with the rest of the player.
  typedef enum logic [1:0] {
    SEQ_PAUSE  = 2'b00,
    SEQ_PLAY   = 2'b01,
    SEQ_SWITCH = 2'b10
  } seqState_e;

  // Advance to the next song, wrapping after the last song in the ROM.
  function automatic logic [1:0] nextSong(input logic [1:0] cur, input logic [1:0] lastSong);
    return (cur == lastSong) ? 2'd0 : cur + 2'd1;
  endfunction

endpackage

// File: rtl/song_sequencer_hold_timer.sv
// hold_timer
// Loadable 4-bit down-counter that times how long reset_player stays high.
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-high reset (count returns to 0)
//   load       in   load load_value this cycle (takes priority over counting)
//   load_value in   [3:0] value loaded into the counter
//   zero       out  high while the count is 0
// The counter decrements every cycle it is not loaded and parks at 0.
module hold_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_value,
  output logic       zero
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  // Load wins over counting; once the count reaches 0 it stays there.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_q != 4'd0) begin
      count_d = count_q - 4'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == 4'd0);

endmodule

// File: rtl/song_sequencer.sv
// song_sequencer
// Playback controller for song_reader. Converts one-cycle button pulses into
// the reader's play level, song select and a restart (reset_player) pulse,
// and reacts to song_done by advancing or rewinding.
// Parameters:
//   NUM_SONGS    number of songs in the ROM (1..4); song index wraps
//   RESET_CYCLES cycles reset_player is held high per switch (1..15)
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-high reset
//   play_button  in   pulse: toggle play / pause
//   next_button  in   pulse: skip to next song
//   song_done    in   last note of the current song finished
//   play         out  registered play level
//   song         out  [1:0] registered song select
//   reset_player out  registered restart for the reader / note player
// Configuration macro: SONG_SEQ_AUTO_ADVANCE_EN
//   defined   -> song_done while playing advances to the next song and keeps playing
//   undefined -> song_done while playing rewinds the same song and pauses
module song_sequencer
  import song_sequencer_pkg::*;
#(
  parameter int NUM_SONGS    = 4,
  parameter int RESET_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       play_button,
  input  logic       next_button,
  input  logic       song_done,
  output logic       play,
  output logic [1:0] song,
  output logic       reset_player
);

  localparam logic [1:0] LastSong = 2'(NUM_SONGS - 1);
  localparam logic [3:0] HoldLoad = 4'(RESET_CYCLES - 1);

  seqState_e  state_q, state_d;
  logic [1:0] song_q, song_d;
  logic       resume_q, resume_d;
  logic       play_q, play_d;
  logic       resetPlayer_q, resetPlayer_d;
  logic       holdLoad;
  logic       holdZero;

  hold_timer u_hold_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (holdLoad),
    .load_value (HoldLoad),
    .zero       (holdZero)
  );

  // Next-state logic. next_button outranks song_done, which outranks
  // play_button; every input is ignored while a switch is in progress.
  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    state_d  = state_q;
    song_d   = song_q;
    resume_d = resume_q;
    holdLoad = 1'b0;
    unique case (state_q)
      SEQ_PAUSE: begin
        if (next_button) begin
          state_d  = SEQ_SWITCH;
          song_d   = nextSong(song_q, LastSong);
          resume_d = 1'b0;
          holdLoad = 1'b1;
        end else if (play_button) begin
          state_d = SEQ_PLAY;
        end
      end
      SEQ_PLAY: begin
        if (next_button) begin
          state_d  = SEQ_SWITCH;
          song_d   = nextSong(song_q, LastSong);
          resume_d = 1'b1;
          holdLoad = 1'b1;
        end else if (song_done) begin
          state_d  = SEQ_SWITCH;
          holdLoad = 1'b1;
`ifdef SONG_SEQ_AUTO_ADVANCE_EN
          song_d   = nextSong(song_q, LastSong);
          resume_d = 1'b1;
`else
          resume_d = 1'b0;
`endif
        end else if (play_button) begin
          state_d = SEQ_PAUSE;
        end
      end
      SEQ_SWITCH: begin
        if (holdZero) begin
          state_d = resume_q ? SEQ_PLAY : SEQ_PAUSE;
        end
      end
      default: begin
        state_d = SEQ_PAUSE;
      end
    endcase
    play_d        = (state_d == SEQ_PLAY);
    resetPlayer_d = (state_d == SEQ_SWITCH);
  end

  // State and output registers; reset aborts any switch in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= SEQ_PAUSE;
      song_q        <= 2'd0;
      resume_q      <= 1'b0;
      play_q        <= 1'b0;
      resetPlayer_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      song_q        <= song_d;
      resume_q      <= resume_d;
      play_q        <= play_d;
      resetPlayer_q <= resetPlayer_d;
    end
  end

  assign play         = play_q;
  assign song         = song_q;
  assign reset_player = resetPlayer_q;

endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer
// Self-checking bench for song_sequencer: a fixed table of single-cycle
// vectors, a few hand-written multi-cycle sequences, then randomized pulses
// compared against a cycle-level behavioural model.
module tb_song_sequencer;

  localparam int NumSongs    = 4;
  localparam int ResetCycles = 2;

`ifdef SONG_SEQ_AUTO_ADVANCE_EN
  localparam bit AutoAdvance = 1'b1;
`else
  localparam bit AutoAdvance = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       play_button;
  logic       next_button;
  logic       song_done;
  logic       play;
  logic [1:0] song;
  logic       reset_player;

  int errors;
  int checks;

  // Behavioural model: song index, whether the listener is "in play mode",
  // how many more cycles the restart pulse lasts, and the mode to resume.
  int mSong;
  bit mPlaying;
  int mHoldLeft;
  bit mResume;

  typedef struct {
    logic       pb;
    logic       nb;
    logic       sd;
    logic       expPlay;
    logic [1:0] expSong;
    logic       expRp;
  } vec_t;

  vec_t vecs[19];

  song_sequencer #(
    .NUM_SONGS    (NumSongs),
    .RESET_CYCLES (ResetCycles)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .play_button  (play_button),
    .next_button  (next_button),
    .song_done    (song_done),
    .play         (play),
    .song         (song),
    .reset_player (reset_player)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mSong     = 0;
    mPlaying  = 1'b0;
    mHoldLeft = 0;
    mResume   = 1'b0;
  endtask

  // One clock edge of the model given the pulses present in that cycle.
  task automatic modelStep(input bit pb, input bit nb, input bit sd);
    if (mHoldLeft > 0) begin
      mHoldLeft--;
      if (mHoldLeft == 0) mPlaying = mResume;
    end else if (nb || (sd && mPlaying)) begin
      if (nb) begin
        mSong   = (mSong + 1) % NumSongs;
        mResume = mPlaying;
      end else if (AutoAdvance) begin
        mSong   = (mSong + 1) % NumSongs;
        mResume = 1'b1;
      end else begin
        mResume = 1'b0;
      end
      mHoldLeft = ResetCycles;
    end else if (pb) begin
      mPlaying = !mPlaying;
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, ".play"}, int'(play), int'(mPlaying && mHoldLeft == 0));
    checkOutput({tag, ".song"}, int'(song), mSong);
    checkOutput({tag, ".reset_player"}, int'(reset_player), int'(mHoldLeft > 0));
  endtask

  // Drive one cycle of pulses, clock once, and sample 1 ns after the edge.
  task automatic applyStimulus(input bit pb, input bit nb, input bit sd);
    play_button = pb;
    next_button = nb;
    song_done   = sd;
    @(posedge clk);
    #1;
    play_button = 1'b0;
    next_button = 1'b0;
    song_done   = 1'b0;
    modelStep(pb, nb, sd);
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    modelReset();
  endtask

  task automatic checkOutputs(input string tag, input bit ePlay, input int eSong, input bit eRp);
    checkOutput({tag, ".play"}, int'(play), int'(ePlay));
    checkOutput({tag, ".song"}, int'(song), eSong);
    checkOutput({tag, ".reset_player"}, int'(reset_player), int'(eRp));
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    reset       = 1'b1;
    play_button = 1'b0;
    next_button = 1'b0;
    song_done   = 1'b0;
    modelReset();

    //                pb    nb    sd    play  song   rp
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutputs("reset", 1'b0, 0, 1'b0);

    // Fixed vector table.
    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].pb, vecs[i].nb, vecs[i].sd);
      checkOutputs($sformatf("vec%0d", i), vecs[i].expPlay, int'(vecs[i].expSong), vecs[i].expRp);
    end

    // song_done while playing song 1: advance or rewind depending on build.
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutputs("done.pre", 1'b1, 1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutputs("done.hold", 1'b0, AutoAdvance ? 2 : 1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutputs("done.after", AutoAdvance, AutoAdvance ? 2 : 1, 1'b0);

    // next_button and song_done together: exactly one advance, keep playing.
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutputs("nbsd.hold", 1'b0, 2, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutputs("nbsd.after", 1'b1, 2, 1'b0);

    // Asynchronous reset in the middle of a switch to song 2.
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutputs("arst.pre", 1'b0, 2, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    checkOutputs("arst.now", 1'b0, 0, 1'b0);
    #1;
    reset = 1'b0;
    modelReset();

    // Randomized pulses against the model, with occasional async resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        #2;
        reset = 1'b1;
        #1;
        modelReset();
        checkModel("rnd.reset");
        #1;
        reset = 1'b0;
      end
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 5) == 0);
      checkModel($sformatf("rnd%0d", c));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
